herring_wait_gen: RTL and testbench
===================================

Name: herring_wait_gen

Overview:
Wait-state generator that sits directly downstream of the address decoder. It consumes the active-low chip selects and the CPU phase-2 clock, and pulls the 65C02 RDY line low to stretch accesses to slow peripherals (VIA, ACIA) by a fixed number of phi2 cycles. It runs on the 50 MHz board oscillator domain and treats phi2 as an asynchronous input.

Parameters:
- SLOW_MASK, 8'b0110_0000: chip-select bits that need wait states (bit5 VIA1, bit6 ACIA1).
- WAIT_CYCLES, 2: extra phi2 cycles inserted per slow access. 0 disables stretching. Legal range 0-15.
- SYNC_STAGES, 2: flip-flop depth of the phi2 synchronizer. Minimum 2.

Ports:
- clk_src  in  1  50 MHz oscillator; the only clock.
- rst  in  1  synchronous, active-high reset.
- phi2  in  1  CPU clock out (PHI2O); asynchronous to clk_src.
- cs_n  in  8  decoder outputs, active low, same bit order as the decoder.
- rw  in  1  CPU RWB (1 = read).
- rdy  out  1  to CPU RDY; 0 = stretch the current cycle.
- wait_active  out  1  high while in WAIT state.
- wait_count  out  8  saturating count of stretched accesses (see Optional Feature).

Behaviour:
- Reset values: rdy=1, wait_active=0, wait_count=0, state=IDLE, cycle counter=0, synchronizer flops=0. Reset asserted mid-wait releases rdy on the next clk_src edge.
- phi2 passes through SYNC_STAGES flops. Rise and fall pulses are one clk_src wide, derived from the last stage versus one extra delayed copy.
- slow_hit = |(~cs_n & SLOW_MASK), sampled in the clk_src cycle of the synced phi2 rise pulse. cs_n and rw are not synchronized because the address is stable when phi2 is high.
- State IDLE: rdy=1.
  - On rise pulse with slow_hit and WAIT_CYCLES != 0: go to WAIT and clear cnt.
  - rdy goes low on the next clk_src edge. Latency from the phi2 pin rising is SYNC_STAGES+1 clk_src cycles, which must land before phi2 falls (guaranteed for INDEX >= 2 dividers).
- State WAIT: rdy=0, wait_active=1.
  - On each fall pulse, cnt increments (4-bit).
  - On a fall pulse with cnt == WAIT_CYCLES-1: go to DONE and set rdy=1.
  - If slow_hit drops on a rise pulse (decode glitch or aborted access): go to IDLE and set rdy=1 immediately.
- State DONE: rdy=1, wait_active=0.
  - Waits for the next fall pulse, where the stretched access completes, then goes to IDLE.
  - DONE exists so the same access is not re-triggered on the following phi2 rise.
- Simultaneous rise pulse and rst: rst wins.
- Rise and fall pulses cannot coincide because the synced phi2 has a single bit.
- Accesses to non-slow selects (RAM, decoder bits 0-4, 7) never affect rdy.
- The rw value does not gate stretching (reads and writes are both stretched). rw is latched into a debug flop only.
- Total stretch per slow access is exactly WAIT_CYCLES phi2 periods.

Optional Feature:
- Macro: HERRING_WAIT_STATS_EN.
- Defined: wait_count increments by 1 on each IDLE->WAIT transition and saturates at 8'hFF. It is cleared only by rst.
- Undefined: the counter logic is omitted and wait_count is tied to 8'h00.
- All other behaviour is identical with and without the macro.

Decomposition:
- Package herring_bus_pkg holds:
  - chip-select index constants: CS_RAM_WR=0, CS_VIA1=5, CS_ACIA1=6, CS_BUS_EN=7;
  - the default slow-device mask;
  - the state enum typedef (IDLE, WAIT, DONE).
- Sub-module herring_edge_sync: parameterized-depth synchronizer plus rise/fall pulse generator. It is reusable for other async board inputs.

Test Plan:
- Reset behaviour: rst held 5 clk_src cycles during WAIT -> rdy=1 and wait_active=0 on the first edge with rst high; after release, stays IDLE until the next slow access.
- ACIA read, WAIT_CYCLES=2, phi2 at clk_src/32: cs_n=8'b1011_1111 held for 3 phi2 periods -> rdy low within 3 clk_src of phi2 rise, high after exactly 2 phi2 falls; wait_count=1 (stats on).
- RAM write: cs_n=8'b1111_1110, rw=0 -> rdy stays 1 throughout, state never leaves IDLE, wait_count unchanged.
- WAIT_CYCLES=0 build with VIA access cs_n=8'b1101_1111 -> rdy constantly 1.
- Abort: VIA selected, then cs_n returns to 8'hFF at the next phi2 rise while in WAIT -> rdy=1 within 1 clk_src of that rise pulse, state IDLE.
- Saturation (stats on): 300 back-to-back ACIA accesses -> wait_count=8'hFF. Build without HERRING_WAIT_STATS_EN -> wait_count=8'h00 throughout.

Source files
------------

// File: rtl/herring_bus_pkg.sv
// Shared bus definitions for the herring board glue logic: decoder
// chip-select indices, the default slow-device mask and the wait-state
// generator state encoding.
package herring_bus_pkg;

  localparam int unsigned CS_W       = 8;
  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned STAT_W     = 8;

  // Decoder output bit positions (cs_n is active low, same order).
  localparam int unsigned CS_RAM_WR = 0;
  localparam int unsigned CS_VIA1   = 5;
  localparam int unsigned CS_ACIA1  = 6;
  localparam int unsigned CS_BUS_EN = 7;

  // Selects whose peripherals cannot keep up with a full-speed phi2 cycle.
  localparam logic [CS_W-1:0] SLOW_MASK_DEFAULT =
    (CS_W'(1) << CS_VIA1) | (CS_W'(1) << CS_ACIA1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } wait_state_e;

endpackage

// File: rtl/herring_edge_sync.sv
// Synchronizer for an asynchronous board input plus single-cycle edge
// pulses in the clk_src domain.
//
// Ports:
//   clk_src  in   sampling clock
//   rst      in   synchronous, active-high reset (all flops to 0)
//   din      in   asynchronous input
//   rise_c   out  one clk_src wide pulse after a synced 0->1 (combinational)
//   fall_c   out  one clk_src wide pulse after a synced 1->0 (combinational)
module herring_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_src,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  if (STAGES < 2) begin : g_bad_stages
    $error("herring_edge_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Metastability chain; dly_q is the extra copy used only for edge detect.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_c =  sync_q[STAGES-1] & ~dly_q;
  assign fall_c = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/herring_wait_gen.sv
// Wait-state generator: pulls the 65C02 RDY low for a fixed number of phi2
// cycles whenever the decoder selects a slow peripheral (VIA, ACIA).
// Runs on the 50 MHz oscillator; phi2 is treated as asynchronous.
//
// Optional build macro HERRING_WAIT_STATS_EN: when defined, wait_count
// counts IDLE->WAIT transitions (saturating at 8'hFF, cleared by rst);
// otherwise wait_count is tied to 8'h00.
//
// Ports:
//   clk_src      in   50 MHz oscillator, the only clock
//   rst          in   synchronous, active-high reset
//   phi2         in   CPU PHI2O, asynchronous to clk_src
//   cs_n[7:0]    in   decoder chip selects, active low
//   rw           in   CPU RWB (1 = read), captured for debug only
//   rdy          out  to CPU RDY; 0 stretches the current cycle
//   wait_active  out  high while stretching
//   wait_count   out  saturating count of stretched accesses
module herring_wait_gen
  import herring_bus_pkg::*;
#(
  parameter logic [7:0]  SLOW_MASK   = SLOW_MASK_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_src,
  input  logic       rst,
  input  logic       phi2,
  input  logic [7:0] cs_n,
  input  logic       rw,
  output logic       rdy,
  output logic       wait_active,
  output logic [7:0] wait_count
);

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("herring_wait_gen: WAIT_CYCLES must be 0..15");
  end

  localparam logic                  STRETCH_EN = (WAIT_CYCLES != 0);
  localparam logic [WAIT_CNT_W-1:0] LAST_CNT   = WAIT_CNT_W'(WAIT_CYCLES - 1);

  logic                  rise_c;
  logic                  fall_c;
  logic                  slow_hit_c;
  logic                  start_c;
  wait_state_e           state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  rw_latched_unused;

  herring_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_phi2_sync (
    .clk_src (clk_src),
    .rst     (rst),
    .din     (phi2),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // cs_n is used raw: the address is stable by the time the synced rise lands.
  assign slow_hit_c = |(~cs_n & SLOW_MASK);
  assign start_c    = (state == IDLE) && rise_c && slow_hit_c && STRETCH_EN;

  // Wait-state FSM with registered rdy / wait_active.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rdy         <= 1'b1;
      wait_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            state       <= WAIT;
            cnt         <= '0;
            rdy         <= 1'b0;
            wait_active <= 1'b1;
          end
        end
        WAIT: begin
          // A select that vanishes at the next rise means the access was aborted.
          if (rise_c && !slow_hit_c) begin
            state       <= IDLE;
            rdy         <= 1'b1;
            wait_active <= 1'b0;
          end else if (fall_c) begin
            cnt <= cnt + WAIT_CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state       <= DONE;
              rdy         <= 1'b1;
              wait_active <= 1'b0;
            end
          end
        end
        DONE: begin
          // Hold off until the stretched access retires so it is not re-triggered.
          if (fall_c) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          rdy         <= 1'b1;
          wait_active <= 1'b0;
        end
      endcase
    end
  end

  // Direction of the last stretched access, kept for probing only.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      rw_latched_unused <= 1'b0;
    end else if (start_c) begin
      rw_latched_unused <= rw;
    end
  end

`ifdef HERRING_WAIT_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of stretched accesses.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      stat_q <= '0;
    end else if (start_c && (stat_q != {STAT_W{1'b1}})) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign wait_count = stat_q;
`else
  assign wait_count = 8'h00;
`endif

endmodule

// File: tb/tb_herring_wait_gen.sv
// Bench for herring_wait_gen: a table of single accesses scored through an
// expected-result queue, plus hand sequences for abort, reset mid-wait and
// counter saturation. A WAIT_CYCLES=0 instance shares the same stimulus.
module tb_herring_wait_gen;
  import herring_bus_pkg::*;

  localparam int W    = 2;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic       clk_src = 1'b0;
  logic       rst;
  logic       phi2;
  logic [7:0] cs_n;
  logic       rw;
  logic       rdy, wait_active;
  logic [7:0] wait_count;
  logic       rdy0, wa0;
  logic [7:0] wc0;

  herring_wait_gen #(
    .SLOW_MASK   (8'b0110_0000),
    .WAIT_CYCLES (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_src     (clk_src),
    .rst         (rst),
    .phi2        (phi2),
    .cs_n        (cs_n),
    .rw          (rw),
    .rdy         (rdy),
    .wait_active (wait_active),
    .wait_count  (wait_count)
  );

  herring_wait_gen #(
    .SLOW_MASK   (8'b0110_0000),
    .WAIT_CYCLES (0),
    .SYNC_STAGES (SYNC)
  ) u_nowait (
    .clk_src     (clk_src),
    .rst         (rst),
    .phi2        (phi2),
    .cs_n        (cs_n),
    .rw          (rw),
    .rdy         (rdy0),
    .wait_active (wa0),
    .wait_count  (wc0)
  );

  always #10 clk_src = ~clk_src;

  int checks = 0;
  int errors = 0;
  int half   = 16;
  int wc_model = 0;

  int cyc = 0;
  always @(posedge clk_src) cyc++;

  // Free-running monitor; tasks take deltas of these totals.
  int   tot_low = 0, tot_wa = 0, tot_str = 0, last_fall_cyc = 0;
  int   nw_low = 0, nw_wc = 0, wc_nz = 0;
  logic rdy_prev = 1'b1;
  always @(negedge clk_src) begin
    if (!rdy) tot_low++;
    if (wait_active) tot_wa++;
    if (rdy_prev && !rdy) begin
      tot_str++;
      last_fall_cyc = cyc;
    end
    rdy_prev = rdy;
    if (!rdy0 || wa0) nw_low++;
    if (wc0 != 8'h00) nw_wc++;
    if (wait_count != 8'h00) wc_nz++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] cs;
    logic       r;
    logic       slow;
  } vec_t;

  typedef struct {
    string name;
    int    lat;
    int    low;
    int    str;
    int    wc;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_wc();
`ifdef HERRING_WAIT_STATS_EN
    return wc_model;
`else
    return 0;
`endif
  endfunction

  function automatic void bump_model();
    if (wc_model < 255) wc_model++;
  endfunction

  // Drive one phi2 half-period; starts and ends 1 time unit after a clk edge.
  task automatic phase(input logic lvl, input logic [7:0] cs, input logic r);
    phi2 = lvl;
    cs_n = cs;
    rw   = r;
    repeat (half) @(posedge clk_src);
    #1;
  endtask

  // Three phi2 periods with the select held, then one idle period.
  task automatic run_access(input string name, input logic [7:0] cs,
                            input logic r, input logic slow);
    exp_t e;
    int l0, w0, s0, t_rise;
    e.name = name;
    e.lat  = slow ? LAT : -1;
    e.low  = slow ? ((W - 1) * 2 * half + half) : 0;
    e.str  = slow ? 1 : 0;
    if (slow) bump_model();
    e.wc   = exp_wc();
    sb.push_back(e);
    l0 = tot_low; w0 = tot_wa; s0 = tot_str; t_rise = cyc;
    repeat (3) begin
      phase(1'b1, cs, r);
      phase(1'b0, cs, r);
    end
    phase(1'b1, 8'hFF, 1'b1);
    phase(1'b0, 8'hFF, 1'b1);
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({e.name, " rdy low cycles"}, tot_low - l0, e.low);
      check({e.name, " wait_active cycles"}, tot_wa - w0, e.low);
      check({e.name, " stretches"}, tot_str - s0, e.str);
      if (e.lat >= 0) check({e.name, " rdy latency"}, last_fall_cyc - t_rise, e.lat);
      check({e.name, " wait_count"}, int'(wait_count), e.wc);
    end
  endtask

  initial begin
    int l0, s0;
    logic [7:0] ram_cs;
    ram_cs = ~(8'h01 << CS_RAM_WR);

    vecs[0] = '{"acia_read",  8'b1011_1111, 1'b1, 1'b1};
    vecs[1] = '{"via_write",  8'b1101_1111, 1'b0, 1'b1};
    vecs[2] = '{"ram_write",  ram_cs,       1'b0, 1'b0};
    vecs[3] = '{"bus_en",     8'b0111_1111, 1'b1, 1'b0};
    vecs[4] = '{"bits1to4",   8'b1110_0001, 1'b1, 1'b0};
    vecs[5] = '{"via_acia",   8'b1001_1111, 1'b1, 1'b1};
    vecs[6] = '{"ram_via",    8'b1101_1110, 1'b0, 1'b1};
    vecs[7] = '{"no_select",  8'hFF,        1'b1, 1'b0};

    rst = 1'b1; phi2 = 1'b0; cs_n = 8'hFF; rw = 1'b1;
    repeat (3) @(posedge clk_src);
    @(negedge clk_src);
    check("reset rdy", int'(rdy), 1);
    check("reset wait_active", int'(wait_active), 0);
    check("reset wait_count", int'(wait_count), 0);
    check("reset rdy nowait", int'(rdy0), 1);
    @(posedge clk_src); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk_src); #1;

    for (int i = 0; i < 8; i++)
      run_access(vecs[i].name, vecs[i].cs, vecs[i].r, vecs[i].slow);

    // Abort: select withdrawn at the second phi2 rise while still waiting.
    l0 = tot_low; s0 = tot_str;
    bump_model();
    phase(1'b1, 8'b1101_1111, 1'b1);
    phase(1'b0, 8'b1101_1111, 1'b1);
    phi2 = 1'b1; cs_n = 8'hFF;
    repeat (2) @(posedge clk_src);
    @(negedge clk_src);
    check("abort still waiting", int'(rdy), 0);
    @(posedge clk_src);
    @(negedge clk_src);
    check("abort rdy", int'(rdy), 1);
    check("abort wait_active", int'(wait_active), 0);
    repeat (half - 3) @(posedge clk_src);
    #1;
    phase(1'b0, 8'hFF, 1'b1);
    phase(1'b1, 8'hFF, 1'b1);
    phase(1'b0, 8'hFF, 1'b1);
    check("abort rdy low cycles", tot_low - l0, 2 * half);
    check("abort stretches", tot_str - s0, 1);
    check("abort wait_count", int'(wait_count), exp_wc());

    // Reset held for five clocks in the middle of a wait.
    phase(1'b1, 8'b1011_1111, 1'b1);
    check("pre-reset rdy", int'(rdy), 0);
    phi2 = 1'b0; cs_n = 8'hFF; rst = 1'b1;
    @(posedge clk_src);
    @(negedge clk_src);
    check("mid-wait reset rdy", int'(rdy), 1);
    check("mid-wait reset wait_active", int'(wait_active), 0);
    repeat (4) @(posedge clk_src);
    #1;
    rst = 1'b0;
    wc_model = 0;
    check("mid-wait reset wait_count", int'(wait_count), 0);
    l0 = tot_low;
    phase(1'b0, 8'hFF, 1'b1);
    repeat (2) begin
      phase(1'b1, 8'hFF, 1'b1);
      phase(1'b0, 8'hFF, 1'b1);
    end
    check("post-reset idle low cycles", tot_low - l0, 0);
    run_access("post_reset_acia", 8'b1011_1111, 1'b1, 1'b1);

    // Back-to-back ACIA accesses at clk/16 to saturate the counter.
    half = 8;
    l0 = tot_low; s0 = tot_str;
    repeat (900) begin
      phase(1'b1, 8'b1011_1111, 1'b1);
      phase(1'b0, 8'b1011_1111, 1'b1);
    end
    phase(1'b1, 8'hFF, 1'b1);
    phase(1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 300; i++) bump_model();
    check("burst stretches", tot_str - s0, 300);
    check("burst rdy low cycles", tot_low - l0, 300 * ((W - 1) * 2 * half + half));
    check("burst wait_count", int'(wait_count), exp_wc());

    check("nowait rdy low samples", nw_low, 0);
    check("nowait wait_count nonzero", nw_wc, 0);
`ifndef HERRING_WAIT_STATS_EN
    check("stats off wait_count nonzero", wc_nz, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
